// File: rtl/scg_pkg.sv
// Shared definitions for the scg_* SDRAM command sequencers: command codes,
// the auto-refresh sequencer state type and a small elaboration helper.
package scg_pkg;

   localparam logic [3:0] CMD_NOP       = 4'd0;
   localparam logic [3:0] CMD_PRECHARGE = 4'd2;
   localparam logic [3:0] CMD_AUTO_REF  = 4'd5;

   typedef enum logic [2:0] {
      StIdle,
      StPre,
      StPreWait,
      StAref,
      StArefWait,
      StDone
   } scg_aref_state_t;

   // Larger of two parameters, for sizing shared timers.
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter with programmable period, used as a wait timer.
// rollover_flag is high in the enabled cycle that completes the period
// (the count_enable cycle in which the count would reach rollover_val);
// the count returns to zero on that same edge.
module flex_counter #(
   parameter int unsigned NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic                    rollover_flag
);

   logic [NUM_CNT_BITS-1:0] count_q, count_d;
   logic [NUM_CNT_BITS:0]   count_inc;

   assign count_inc     = {1'b0, count_q} + {{NUM_CNT_BITS{1'b0}}, 1'b1};
   assign rollover_flag = count_enable && (count_inc == {1'b0, rollover_val});

   // Next count: clear wins, otherwise advance and wrap at the end of the period.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_enable) begin
         count_d = rollover_flag ? '0 : count_inc[NUM_CNT_BITS-1:0];
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/scg_auto_ref_multi.sv
// SDRAM auto-refresh burst sequencer. On start it issues n_lat AUTO REFRESH
// commands spaced TRFC_CYCLES apart, then pulses done for one cycle.
// Optional: define SCG_AUTO_REF_PRECHARGE_EN to precede a non-empty burst with
// PRECHARGE ALL followed by a TRP_CYCLES window.
module scg_auto_ref_multi
   import scg_pkg::*;
#(
   parameter int unsigned MAX_REFS    = 8,
   parameter int unsigned TRFC_CYCLES = 8,
   parameter int unsigned TRP_CYCLES  = 3,
   parameter int unsigned REF_BITS    = $clog2(MAX_REFS + 1)
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start,
   input  logic [REF_BITS-1:0] num_refs,
   output logic                busy,
   output logic                done,
   output logic [REF_BITS-1:0] ref_index,
   output logic [3:0]          command
);

   // One timer serves both tRFC and tRP, so size it for the longer period.
   localparam int unsigned          CNT_W      = $clog2(max_u(TRFC_CYCLES, TRP_CYCLES));
   localparam logic [CNT_W-1:0]     TRFC_LAST  = CNT_W'(TRFC_CYCLES - 1);
   localparam logic [REF_BITS-1:0]  MAX_REFS_L = REF_BITS'(MAX_REFS);

`ifdef SCG_AUTO_REF_PRECHARGE_EN
   localparam logic [CNT_W-1:0]     TRP_LAST   = CNT_W'(TRP_CYCLES - 1);
   localparam scg_aref_state_t      FIRST_ST   = StPre;
`else
   localparam scg_aref_state_t      FIRST_ST   = StAref;
`endif

   scg_aref_state_t     state_q, state_d;
   logic [REF_BITS-1:0] n_lat_q, n_lat_d;
   logic [REF_BITS-1:0] ref_index_q, ref_index_d;
   logic [REF_BITS-1:0] num_sat;
   logic                timer_en;
   logic                timer_clear;
   logic [CNT_W-1:0]    timer_last;
   logic                timer_done;

   assign num_sat = (num_refs > MAX_REFS_L) ? MAX_REFS_L : num_refs;

   // Next-state and command decode.
   always_comb begin
      state_d    = state_q;
      command    = CMD_NOP;
      timer_en   = 1'b0;
      timer_last = TRFC_LAST;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = (num_sat == '0) ? StDone : FIRST_ST;
            end
         end
`ifdef SCG_AUTO_REF_PRECHARGE_EN
         StPre: begin
            command = CMD_PRECHARGE;
            state_d = StPreWait;
         end
         StPreWait: begin
            timer_en   = 1'b1;
            timer_last = TRP_LAST;
            if (timer_done) begin
               state_d = StAref;
            end
         end
`endif
         StAref: begin
            command = CMD_AUTO_REF;
            state_d = StArefWait;
         end
         StArefWait: begin
            timer_en = 1'b1;
            if (timer_done) begin
               // ref_index already counts the refresh just issued.
               state_d = (ref_index_q < n_lat_q) ? StAref : StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Timer restarts from zero in every state it is used in.
   assign timer_clear = (state_d != state_q);

   flex_counter #(
      .NUM_CNT_BITS (CNT_W)
   ) u_wait_timer (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (timer_clear),
      .count_enable  (timer_en),
      .rollover_val  (timer_last),
      .rollover_flag (timer_done)
   );

   // Burst length capture and refresh counting.
   always_comb begin
      n_lat_d     = n_lat_q;
      ref_index_d = ref_index_q;
      if (state_q == StIdle && start) begin
         n_lat_d = num_sat;
      end
      if (state_q == StAref) begin
         ref_index_d = ref_index_q + REF_BITS'(1);
      end else if (state_q == StDone) begin
         ref_index_d = '0;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= StIdle;
         n_lat_q     <= '0;
         ref_index_q <= '0;
      end else begin
         state_q     <= state_d;
         n_lat_q     <= n_lat_d;
         ref_index_q <= ref_index_d;
      end
   end

   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StDone);
   assign ref_index = ref_index_q;

endmodule

// File: tb/tb_scg_auto_ref_multi.sv
// Self-checking bench for scg_auto_ref_multi: directed bursts plus randomized
// bursts with mid-burst start/num_refs noise, checked every cycle against a
// timeline model derived from the burst timing rules.
module tb_scg_auto_ref_multi;

   localparam int MAX_REFS = 8;
   localparam int TRFC     = 8;
   localparam int TRP      = 3;
   localparam int RB       = $clog2(MAX_REFS + 1);
`ifdef SCG_AUTO_REF_PRECHARGE_EN
   localparam int PRE_OFF  = TRP;
`else
   localparam int PRE_OFF  = 0;
`endif

   logic          clk;
   logic          n_rst;
   logic          start;
   logic [RB-1:0] num_refs;
   logic          busy;
   logic          done;
   logic [RB-1:0] ref_index;
   logic [3:0]    command;

   int n_tests;
   int n_fail;

   scg_auto_ref_multi #(
      .MAX_REFS    (MAX_REFS),
      .TRFC_CYCLES (TRFC),
      .TRP_CYCLES  (TRP),
      .REF_BITS    (RB)
   ) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .start     (start),
      .num_refs  (num_refs),
      .busy      (busy),
      .done      (done),
      .ref_index (ref_index),
      .command   (command)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected outputs in cycle c (1 = first cycle after start is accepted)
   // of a burst of n refreshes. Cycle d is DONE; beyond d the block is idle.
   function automatic void model(input int n, input int c, output int cmd, output int bsy,
                                 output int dn, output int idx);
      int d;
      d   = (n == 0) ? 1 : 1 + PRE_OFF + n * TRFC;
      cmd = 0;
      bsy = (c >= 1 && c <= d) ? 1 : 0;
      dn  = (c == d) ? 1 : 0;
      idx = 0;
      if (n > 0) begin
         if (PRE_OFF > 0 && c == 1) cmd = 2;
         for (int k = 1; k <= n; k++) begin
            int t;
            t = 1 + PRE_OFF + (k - 1) * TRFC;
            if (c == t) cmd = 5;
            if (t < c) idx++;
         end
      end
      if (c > d) idx = 0;
   endfunction

   task automatic check_cycle(input string name, input int n, input int c);
      int cmd, bsy, dn, idx;
      model(n, c, cmd, bsy, dn, idx);
      check($sformatf("%s command c%0d", name, c), int'(command), cmd);
      check($sformatf("%s busy c%0d", name, c), int'(busy), bsy);
      check($sformatf("%s done c%0d", name, c), int'(done), dn);
      check($sformatf("%s ref_index c%0d", name, c), int'(ref_index), idx);
   endtask

   task automatic check_idle(input string name);
      check({name, " command"}, int'(command), 0);
      check({name, " busy"}, int'(busy), 0);
      check({name, " done"}, int'(done), 0);
      check({name, " ref_index"}, int'(ref_index), 0);
   endtask

   // One burst from idle; with noise, start/num_refs toggle randomly mid-burst.
   task automatic run_burst(input string name, input int num, input bit noise);
      int n, d;
      n = (num > MAX_REFS) ? MAX_REFS : num;
      d = (n == 0) ? 1 : 1 + PRE_OFF + n * TRFC;
      @(negedge clk);
      start    = 1'b1;
      num_refs = RB'(num);
      @(posedge clk);
      #1;
      start    = 1'b0;
      num_refs = RB'($urandom);
      for (int c = 1; c <= d + 1; c++) begin
         @(negedge clk);
         check_cycle(name, n, c);
         if (noise && c < d) begin
            start    = 1'($urandom_range(0, 1));
            num_refs = RB'($urandom);
         end else begin
            start = 1'b0;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      n_tests  = 0;
      n_fail   = 0;
      n_rst    = 1'b0;
      start    = 1'b0;
      num_refs = '0;
      #1;
      check_idle("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      check_idle("post-reset");

      run_burst("two", 2, 1'b0);
      run_burst("zero", 0, 1'b0);
      run_burst("sat15", 15, 1'b0);

      // start held high with one refresh per burst: bursts repeat every p cycles.
      p = 1 + PRE_OFF + TRFC + 1;
      @(negedge clk);
      start    = 1'b1;
      num_refs = RB'(1);
      @(posedge clk);
      for (int c = 1; c <= 3 * p; c++) begin
         int local_c;
         @(negedge clk);
         local_c = ((c - 1) % p) + 1;
         check_cycle("held", 1, local_c);
         if (c == 3 * p) start = 1'b0;
      end
      @(negedge clk);
      check_idle("held end");

      // Reset dropped in cycle 5 of a 3-refresh burst.
      @(negedge clk);
      start    = 1'b1;
      num_refs = RB'(3);
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         check_cycle("pre-rst", 3, c);
      end
      n_rst = 1'b0;
      #1;
      check_idle("async rst");
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("in rst");
      n_rst = 1'b1;
      @(negedge clk);
      check_idle("after rst");
      run_burst("post-rst", 3, 1'b0);

      for (int i = 0; i < 25; i++) begin
         run_burst($sformatf("rand%0d", i), int'($urandom_range(0, 15)), 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
